dcache_data_read_pipe: RTL and testbench

- Two-lane, two-stage read pipeline downstream of the data-array read arbiter.
- Accepts the winning request pair: per-lane way_en, addr, lane valid.
- Registers the pair, checks the two lanes for bank conflicts, drives per-lane SRAM read ports and returns per-lane row data two cycles after acceptance.
- Honours late per-lane kills from the LSU and keeps a saturating conflict counter for perf.

---
 rtl/dcache_data_read_pipe_if.sv | 62 ++++++
 rtl/dcache_data_read_pipe.sv | 106 ++++++++++
 tb/tb_dcache_data_read_pipe.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_data_read_pipe_if.sv
// Request, kill, SRAM read-port and response bundle for the two-lane dcache data read pipe.
// Latency: none; signal grouping only.
// Backpressure: io_req_ready (driven by the pipe) qualifies io_req_valid; nothing downstream stalls.
// Ports: slave = the read pipe; master = arbiter / LSU / SRAM side driving the pipe.
interface dcache_data_read_pipe_if #(
    parameter int NWAYS   = 8,
    parameter int ROWBITS = 64,
    parameter int ADDR_W  = 12,
    parameter int ROW_OFF = 3,
    parameter int NBANKS  = 2
) ();
    localparam int BANK_W = $clog2(NBANKS);
    localparam int IDX_W  = ADDR_W - ROW_OFF - BANK_W;

    logic                     io_req_valid;
    logic                     io_req_ready;
    logic [NWAYS-1:0]         io_req_0_way_en;
    logic [NWAYS-1:0]         io_req_1_way_en;
    logic [ADDR_W-1:0]        io_req_0_addr;
    logic [ADDR_W-1:0]        io_req_1_addr;
    logic                     io_req_valid_0;
    logic                     io_req_valid_1;
    logic                     io_wr_busy;
    logic                     io_s1_kill_0;
    logic                     io_s1_kill_1;
    logic                     io_sram_0_en;
    logic                     io_sram_1_en;
    logic [BANK_W-1:0]        io_sram_0_bank;
    logic [BANK_W-1:0]        io_sram_1_bank;
    logic [IDX_W-1:0]         io_sram_0_idx;
    logic [IDX_W-1:0]         io_sram_1_idx;
    logic [NWAYS-1:0]         io_sram_0_way_en;
    logic [NWAYS-1:0]         io_sram_1_way_en;
    logic [NWAYS*ROWBITS-1:0] io_sram_0_rdata;
    logic [NWAYS*ROWBITS-1:0] io_sram_1_rdata;
    logic                     io_nack_1;
    logic                     io_resp_0_valid;
    logic                     io_resp_1_valid;
    logic [NWAYS*ROWBITS-1:0] io_resp_0_data;
    logic [NWAYS*ROWBITS-1:0] io_resp_1_data;
    logic [15:0]              io_conflict_count;

    modport slave (
        input  io_req_valid, io_req_0_way_en, io_req_1_way_en, io_req_0_addr, io_req_1_addr,
               io_req_valid_0, io_req_valid_1, io_wr_busy, io_s1_kill_0, io_s1_kill_1,
               io_sram_0_rdata, io_sram_1_rdata,
        output io_req_ready, io_sram_0_en, io_sram_1_en, io_sram_0_bank, io_sram_1_bank,
               io_sram_0_idx, io_sram_1_idx, io_sram_0_way_en, io_sram_1_way_en,
               io_nack_1, io_resp_0_valid, io_resp_1_valid, io_resp_0_data, io_resp_1_data,
               io_conflict_count
    );

    modport master (
        output io_req_valid, io_req_0_way_en, io_req_1_way_en, io_req_0_addr, io_req_1_addr,
               io_req_valid_0, io_req_valid_1, io_wr_busy, io_s1_kill_0, io_s1_kill_1,
               io_sram_0_rdata, io_sram_1_rdata,
        input  io_req_ready, io_sram_0_en, io_sram_1_en, io_sram_0_bank, io_sram_1_bank,
               io_sram_0_idx, io_sram_1_idx, io_sram_0_way_en, io_sram_1_way_en,
               io_nack_1, io_resp_0_valid, io_resp_1_valid, io_resp_0_data, io_resp_1_data,
               io_conflict_count
    );
endinterface

// File: rtl/dcache_data_read_pipe.sv
// Two-lane dcache data read pipe: registers a request pair, resolves bank conflicts/merges, reads SRAM, returns rows.
// Latency: accept in t, SRAM enable in t+1, response in t+2; one pair per cycle.
// Backpressure: io_req_ready = ~io_wr_busy only gates stage 0; in-flight stages always complete.
// Ports: clock, reset (sync, active-high), io (slave view: request pair, kills, SRAM ports, responses, conflict count).
module dcache_data_read_pipe #(
    parameter int NWAYS   = 8,
    parameter int ROWBITS = 64,
    parameter int ADDR_W  = 12,
    parameter int ROW_OFF = 3,
    parameter int NBANKS  = 2
) (
    input logic                   clock,
    input logic                   reset,
    dcache_data_read_pipe_if.slave io
);
    localparam int BANK_W = $clog2(NBANKS);
    localparam int ROW_W  = ADDR_W - ROW_OFF;   // bank + idx, byte offset dropped

    logic              accept;
    logic              s1_v0, s1_v1;
    logic [NWAYS-1:0]  s1_way0, s1_way1;
    logic [ROW_W-1:0]  s1_row0, s1_row1;
    logic              s1_l0, s1_l1;
    logic              same_bank, same_idx;
    logic              conflict, merge;
    logic              s2_v0, s2_v1, s2_fwd1;
    logic [15:0]       conflict_count;
    logic              unused_addr_lsbs;

    assign io.io_req_ready = ~io.io_wr_busy;
    assign accept          = io.io_req_valid & ~io.io_wr_busy;

    // Byte offset within the row never reaches the SRAM.
    assign unused_addr_lsbs = ^{io.io_req_0_addr[ROW_OFF-1:0], io.io_req_1_addr[ROW_OFF-1:0]};

    // Stage 1 valids: a cycle without accept leaves a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v0 <= 1'b0;
            s1_v1 <= 1'b0;
        end else begin
            s1_v0 <= accept & io.io_req_valid_0;
            s1_v1 <= accept & io.io_req_valid_1;
        end
    end

    // Stage 1 payload: only meaningful when the matching valid is set.
    always_ff @(posedge clock) begin
        if (accept) begin
            s1_way0 <= io.io_req_0_way_en;
            s1_way1 <= io.io_req_1_way_en;
            s1_row0 <= io.io_req_0_addr[ADDR_W-1:ROW_OFF];
            s1_row1 <= io.io_req_1_addr[ADDR_W-1:ROW_OFF];
        end
    end

    // Late kills drop lanes before they can conflict or merge.
    assign s1_l0     = s1_v0 & ~io.io_s1_kill_0;
    assign s1_l1     = s1_v1 & ~io.io_s1_kill_1;
    assign same_bank = (s1_row0[BANK_W-1:0] == s1_row1[BANK_W-1:0]);
    assign same_idx  = (s1_row0[ROW_W-1:BANK_W] == s1_row1[ROW_W-1:BANK_W]);
    assign conflict  = s1_l0 & s1_l1 & same_bank & ~same_idx;
    assign merge     = s1_l0 & s1_l1 & same_bank & same_idx;

    // Port 0 serves lane 0; on a merge it also powers lane 1's ways so one read covers both.
    assign io.io_sram_0_en     = s1_l0;
    assign io.io_sram_0_bank   = s1_row0[BANK_W-1:0];
    assign io.io_sram_0_idx    = s1_row0[ROW_W-1:BANK_W];
    assign io.io_sram_0_way_en = merge ? (s1_way0 | s1_way1) : s1_way0;

    assign io.io_sram_1_en     = s1_l1 & ~conflict & ~merge;
    assign io.io_sram_1_bank   = s1_row1[BANK_W-1:0];
    assign io.io_sram_1_idx    = s1_row1[ROW_W-1:BANK_W];
    assign io.io_sram_1_way_en = s1_way1;

    assign io.io_nack_1 = conflict;

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_v0   <= 1'b0;
            s2_v1   <= 1'b0;
            s2_fwd1 <= 1'b0;
        end else begin
            s2_v0   <= s1_l0;
            s2_v1   <= s1_l1 & ~conflict;
            s2_fwd1 <= merge;
        end
    end

    // Stage 2 data comes straight off the SRAM; merged lane 1 reads port 0.
    assign io.io_resp_0_valid = s2_v0;
    assign io.io_resp_0_data  = io.io_sram_0_rdata;
    assign io.io_resp_1_valid = s2_v1;
    assign io.io_resp_1_data  = s2_fwd1 ? io.io_sram_0_rdata : io.io_sram_1_rdata;

    // Perf counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            conflict_count <= 16'h0000;
        end else if (conflict && (conflict_count != 16'hFFFF)) begin
            conflict_count <= conflict_count + 16'd1;
        end
    end

    assign io.io_conflict_count = conflict_count;
endmodule

// File: tb/tb_dcache_data_read_pipe.sv
module tb_dcache_data_read_pipe;
    localparam logic [511:0] POISON0 = {8{64'hBAD0_BAD0_BAD0_BAD0}};
    localparam logic [511:0] POISON1 = {8{64'hBAD1_BAD1_BAD1_BAD1}};

    typedef struct {
        int           due;
        logic         v0;
        logic         v1;
        logic [511:0] d0;
        logic [511:0] d1;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        pk0 = 1'b0;
    logic        pk1 = 1'b0;
    logic [15:0] exp_count = 16'h0000;
    exp_t        q[$];

    dcache_data_read_pipe_if bus ();

    dcache_data_read_pipe dut (
        .clock(clock),
        .reset(reset),
        .io   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Row content is a function of bank/idx; a disabled port returns poison.
    always @(posedge clock) begin
        bus.io_sram_0_rdata <= bus.io_sram_0_en ?
            {8{40'hDA7A5EED00, bus.io_sram_0_idx, 15'h0, bus.io_sram_0_bank}} : POISON0;
        bus.io_sram_1_rdata <= bus.io_sram_1_en ?
            {8{40'hDA7A5EED00, bus.io_sram_1_idx, 15'h0, bus.io_sram_1_bank}} : POISON1;
    end

    function automatic logic [511:0] row_of(input logic [11:0] a);
        logic [63:0] w;
        w = {40'hDA7A5EED00, a[11:4], 15'h0, a[3]};
        return {8{w}};
    endfunction

    // Scoreboard: every cycle the responses must match the entry due now, or be idle.
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            e = '{due: 0, v0: 1'b0, v1: 1'b0, d0: '0, d1: '0};
            while (q.size() > 0 && q[0].due < cyc) begin
                errors++;
                $display("FAIL sb_stale got due %0d want >= %0d", q[0].due, cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
            checks++;
            if (bus.io_resp_0_valid !== e.v0) begin
                errors++;
                $display("FAIL resp0_valid cyc %0d got %b want %b", cyc, bus.io_resp_0_valid, e.v0);
            end
            checks++;
            if (bus.io_resp_1_valid !== e.v1) begin
                errors++;
                $display("FAIL resp1_valid cyc %0d got %b want %b", cyc, bus.io_resp_1_valid, e.v1);
            end
            if (e.v0) begin
                checks++;
                if (bus.io_resp_0_data !== e.d0) begin
                    errors++;
                    $display("FAIL resp0_data cyc %0d got %h want %h", cyc, bus.io_resp_0_data[63:0], e.d0[63:0]);
                end
            end
            if (e.v1) begin
                checks++;
                if (bus.io_resp_1_data !== e.d1) begin
                    errors++;
                    $display("FAIL resp1_data cyc %0d got %h want %h", cyc, bus.io_resp_1_data[63:0], e.d1[63:0]);
                end
            end
        end
    end

    // Advance one cycle, then apply the kills belonging to the pair now in stage 1.
    task automatic tick();
        @(posedge clock);
        #1;
        bus.io_s1_kill_0 = pk0;
        bus.io_s1_kill_1 = pk1;
        pk0 = 1'b0;
        pk1 = 1'b0;
    endtask

    task automatic idle();
        bus.io_req_valid   = 1'b0;
        bus.io_req_valid_0 = 1'b0;
        bus.io_req_valid_1 = 1'b0;
    endtask

    // Drive one request pair; if it will be accepted, push its expected response.
    task automatic step(input logic v0, input logic v1, input logic [11:0] a0, input logic [11:0] a1,
                        input logic [7:0] w0, input logic [7:0] w1, input logic k0, input logic k1);
        exp_t e;
        logic l0, l1, cf;
        bus.io_req_valid    = 1'b1;
        bus.io_req_valid_0  = v0;
        bus.io_req_valid_1  = v1;
        bus.io_req_0_addr   = a0;
        bus.io_req_1_addr   = a1;
        bus.io_req_0_way_en = w0;
        bus.io_req_1_way_en = w1;
        if (!bus.io_wr_busy) begin
            l0 = v0 & ~k0;
            l1 = v1 & ~k1;
            cf = l0 & l1 & (a0[3] == a1[3]) & (a0[11:4] != a1[11:4]);
            e.due = cyc + 2;
            e.v0  = l0;
            e.v1  = l1 & ~cf;
            e.d0  = row_of(a0);
            e.d1  = row_of(a1);
            q.push_back(e);
            pk0 = k0;
            pk1 = k1;
            if (cf && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.io_sram_0_en !== 1'b0 || bus.io_sram_1_en !== 1'b0 || bus.io_nack_1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got en0 %b en1 %b nack %b want 0 0 0",
                     bus.io_sram_0_en, bus.io_sram_1_en, bus.io_nack_1);
        end
        checks++;
        if (bus.io_conflict_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_count got %h want 0000", bus.io_conflict_count);
        end
        checks++;
        if (bus.io_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bus.io_req_ready);
        end
    endtask

    task automatic test_single_lane0();
        step(1'b1, 1'b0, 12'h0A8, 12'h000, 8'h04, 8'h00, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (bus.io_sram_0_en !== 1'b1 || bus.io_sram_0_bank !== 1'b1 || bus.io_sram_0_idx !== 8'h0A
            || bus.io_sram_0_way_en !== 8'h04) begin
            errors++;
            $display("FAIL single_port0 got en %b bank %b idx %h way %h want 1 1 0a 04",
                     bus.io_sram_0_en, bus.io_sram_0_bank, bus.io_sram_0_idx, bus.io_sram_0_way_en);
        end
        checks++;
        if (bus.io_sram_1_en !== 1'b0 || bus.io_nack_1 !== 1'b0) begin
            errors++;
            $display("FAIL single_port1 got en1 %b nack %b want 0 0", bus.io_sram_1_en, bus.io_nack_1);
        end
        tick();
        tick();
    endtask

    task automatic test_conflict();
        step(1'b1, 1'b1, 12'h010, 12'h110, 8'h01, 8'h02, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (bus.io_nack_1 !== 1'b1 || bus.io_sram_1_en !== 1'b0 || bus.io_sram_0_en !== 1'b1
            || bus.io_sram_0_idx !== 8'h01) begin
            errors++;
            $display("FAIL conflict_stage1 got nack %b en1 %b en0 %b idx0 %h want 1 0 1 01",
                     bus.io_nack_1, bus.io_sram_1_en, bus.io_sram_0_en, bus.io_sram_0_idx);
        end
        tick();
        tick();
        checks++;
        if (bus.io_conflict_count !== 16'h0001) begin
            errors++;
            $display("FAIL conflict_count got %h want 0001", bus.io_conflict_count);
        end
    endtask

    task automatic test_two_banks();
        step(1'b1, 1'b1, 12'h040, 12'h048, 8'h80, 8'h08, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (bus.io_sram_0_en !== 1'b1 || bus.io_sram_1_en !== 1'b1 || bus.io_nack_1 !== 1'b0) begin
            errors++;
            $display("FAIL banks_en got en0 %b en1 %b nack %b want 1 1 0",
                     bus.io_sram_0_en, bus.io_sram_1_en, bus.io_nack_1);
        end
        checks++;
        if (bus.io_sram_0_idx !== 8'h04 || bus.io_sram_1_idx !== 8'h04 || bus.io_sram_0_bank !== 1'b0
            || bus.io_sram_1_bank !== 1'b1 || bus.io_sram_1_way_en !== 8'h08) begin
            errors++;
            $display("FAIL banks_addr got idx %h/%h bank %b/%b way1 %h want 04/04 0/1 08",
                     bus.io_sram_0_idx, bus.io_sram_1_idx, bus.io_sram_0_bank, bus.io_sram_1_bank,
                     bus.io_sram_1_way_en);
        end
        tick();
        tick();
    endtask

    task automatic test_merge();
        step(1'b1, 1'b1, 12'h200, 12'h204, 8'h01, 8'h10, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (bus.io_sram_0_en !== 1'b1 || bus.io_sram_1_en !== 1'b0 || bus.io_nack_1 !== 1'b0
            || bus.io_sram_0_way_en !== 8'h11) begin
            errors++;
            $display("FAIL merge_stage1 got en0 %b en1 %b nack %b way0 %h want 1 0 0 11",
                     bus.io_sram_0_en, bus.io_sram_1_en, bus.io_nack_1, bus.io_sram_0_way_en);
        end
        tick();
        tick();
    endtask

    task automatic test_kill();
        step(1'b1, 1'b1, 12'h010, 12'h110, 8'h01, 8'h02, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (bus.io_nack_1 !== 1'b0 || bus.io_sram_1_en !== 1'b1 || bus.io_sram_0_en !== 1'b0
            || bus.io_sram_1_idx !== 8'h11) begin
            errors++;
            $display("FAIL kill_stage1 got nack %b en1 %b en0 %b idx1 %h want 0 1 0 11",
                     bus.io_nack_1, bus.io_sram_1_en, bus.io_sram_0_en, bus.io_sram_1_idx);
        end
        tick();
        tick();
        checks++;
        if (bus.io_conflict_count !== exp_count) begin
            errors++;
            $display("FAIL kill_count got %h want %h", bus.io_conflict_count, exp_count);
        end
    endtask

    task automatic test_wr_busy();
        bus.io_wr_busy = 1'b1;
        step(1'b1, 1'b1, 12'h040, 12'h048, 8'hFF, 8'hFF, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.io_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready got %b want 0", bus.io_req_ready);
        end
        tick();
        bus.io_wr_busy = 1'b0;
        idle();
        #1;
        checks++;
        if (bus.io_sram_0_en !== 1'b0 || bus.io_sram_1_en !== 1'b0) begin
            errors++;
            $display("FAIL busy_issue got en0 %b en1 %b want 0 0", bus.io_sram_0_en, bus.io_sram_1_en);
        end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [11:0] a0, a1;
        for (int i = 0; i < 24; i++) begin
            a0 = 12'($urandom_range(0, 15)) << 3;
            a1 = 12'($urandom_range(0, 15)) << 3;
            step(1'($urandom_range(0, 1)) | (i < 4 ? 1'b1 : 1'b0), 1'($urandom_range(0, 1)), a0, a1,
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
            tick();
        end
        idle();
        tick();
        tick();
        checks++;
        if (bus.io_conflict_count !== exp_count) begin
            errors++;
            $display("FAIL b2b_count got %h want %h", bus.io_conflict_count, exp_count);
        end
    endtask

    task automatic test_saturation();
        int n;
        n = int'(16'hFFFE - exp_count);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, 12'h010, 12'h110, 8'h01, 8'h02, 1'b0, 1'b0);
            tick();
        end
        idle();
        tick();
        tick();
        checks++;
        if (bus.io_conflict_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_preload got %h want fffe", bus.io_conflict_count);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 12'h030, 12'h130, 8'h01, 8'h02, 1'b0, 1'b0);
            tick();
        end
        idle();
        tick();
        tick();
        checks++;
        if (bus.io_conflict_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got %h want ffff", bus.io_conflict_count);
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 1'b1, 12'h040, 12'h048, 8'h01, 8'h01, 1'b0, 1'b0);
        tick();
        idle();
        reset = 1'b1;
        q.delete();
        exp_count = 16'h0000;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (bus.io_sram_0_en !== 1'b0 || bus.io_sram_1_en !== 1'b0 || bus.io_conflict_count !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid got en0 %b en1 %b count %h want 0 0 0000",
                     bus.io_sram_0_en, bus.io_sram_1_en, bus.io_conflict_count);
        end
        tick();
        #1;
        checks++;
        if (bus.io_sram_0_en !== 1'b0 || bus.io_sram_1_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_after got en0 %b en1 %b want 0 0", bus.io_sram_0_en, bus.io_sram_1_en);
        end
        tick();
        tick();
    endtask

    initial begin
        bus.io_wr_busy      = 1'b0;
        bus.io_s1_kill_0    = 1'b0;
        bus.io_s1_kill_1    = 1'b0;
        bus.io_req_0_addr   = '0;
        bus.io_req_1_addr   = '0;
        bus.io_req_0_way_en = '0;
        bus.io_req_1_way_en = '0;
        idle();
        repeat (3) tick();
        reset = 1'b0;
        mon_en = 1'b1;
        test_reset();
        tick();
        test_single_lane0();
        test_conflict();
        test_two_banks();
        test_merge();
        test_kill();
        test_wr_busy();
        test_back_to_back();
        test_saturation();
        test_reset_midflight();
        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
